// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding, sizing defaults and ID/EX NOP control values for the
// decode-stage pipeline controller.
package pipe_ctrl_pkg;

    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned REG_AW_DEF   = 5;
    localparam int unsigned CNT_W_DEF    = 2;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } ctrl_state_e;

    // Control values the decode stage loads into ID/EX when a bubble is inserted.
    localparam logic RWrEn_Disable = 1'b0;
    localparam logic MemRW_Read    = 1'b0;
    localparam logic BR_Disable    = 1'b0;
    localparam logic JMP_Disable   = 1'b0;

    typedef struct packed {
        logic rwren;
        logic memrw;
        logic br;
        logic jmp;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t NOP_CTRL = '{
        rwren: RWrEn_Disable,
        memrw: MemRW_Read,
        br:    BR_Disable,
        jmp:   JMP_Disable
    };

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register count of in-flight writebacks. x0 is never tracked; a writer and a
// retirer hitting the same register in one cycle leave its count unchanged.
module reg_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic [REG_AW-1:0] inc_rd,
    input  logic              dec,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              busy1,
    output logic              busy2,
    output logic              all_clear
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             inc_hit;
    logic             dec_hit;
    logic             same_rd;

    assign inc_hit = inc && (inc_rd != REG_AW'(ZERO_REG));
    assign dec_hit = dec && (dec_rd != REG_AW'(ZERO_REG));
    assign same_rd = inc_hit && dec_hit && (inc_rd == dec_rd);

    // Out-of-range updates saturate; the assertions below flag them.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (!same_rd) begin
                if (inc_hit && inc_rd == REG_AW'(r) && cnt_q[r] != CNT_MAX) begin
                    cnt_d[r] = cnt_q[r] + 1'b1;
                end
                if (dec_hit && dec_rd == REG_AW'(r) && cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy1 = (cnt_q[rs1] != '0);
    assign busy2 = (cnt_q[rs2] != '0);

    always_comb begin
        all_clear = 1'b1;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (cnt_q[r] != '0) begin
                all_clear = 1'b0;
            end
        end
    end

    inc_overflow: assert property (@(posedge clk) disable iff (rst)
        !(inc_hit && !same_rd && cnt_q[inc_rd] == CNT_MAX));

    dec_underflow: assert property (@(posedge clk) disable iff (rst)
        !(dec_hit && !same_rd && cnt_q[dec_rd] == '0));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage pipeline controller: RAW stall against the writeback scoreboard,
// wrong-path squash on EX redirect, and drain-then-park after a halting instruction.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rwren,
    input  logic              id_halt,
    input  logic              wb_rwren,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              ex_redirect,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic              flush_if_id,
    output logic              issue,
    output logic              halted,
    output logic [1:0]        state
);

    ctrl_state_e state_q, state_d;
    logic        inc, dec;
    logic        busy1, busy2, all_clear;
    logic        hazard;

    // The halting instruction's rd is never tracked, so drain can complete.
    assign inc = issue && id_rwren && (id_rd != REG_AW'(ZERO_REG)) && !id_halt;
    assign dec = wb_rwren && (wb_rd != REG_AW'(ZERO_REG));

    assign hazard = id_valid &&
        ((id_rs1_used && (id_rs1 != REG_AW'(ZERO_REG)) && busy1) ||
         (id_rs2_used && (id_rs2 != REG_AW'(ZERO_REG)) && busy2));

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW),
        .CNT_W    (CNT_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc),
        .inc_rd    (id_rd),
        .dec       (dec),
        .dec_rd    (wb_rd),
        .rs1       (id_rs1),
        .rs2       (id_rs2),
        .busy1     (busy1),
        .busy2     (busy2),
        .all_clear (all_clear)
    );

    always_comb begin
        state_d      = state_q;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        issue        = 1'b0;
        halted       = 1'b0;
        unique case (state_q)
            StRun: begin
                if (ex_redirect) begin
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end else if (hazard) begin
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end else begin
                    issue = id_valid;
                    if (id_valid && id_halt) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
                if (all_clear) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
                halted       = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic fed through a three-stage writeback pipe and an integer reference model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs1_used, id_rs2_used, id_rwren, id_halt;
    logic       wb_rwren, ex_redirect;
    logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic       stall_if_id, bubble_id_ex, flush_if_id, issue, halted;
    logic [1:0] state;
    logic [6:0] dut_vec;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-register in-flight counts, state (0 run, 1 drain, 2 halted),
    // and the rd carried by EX/MEM/WB (-1 when the slot writes nothing).
    int m_cnt [32];
    int m_state;
    int p_ex, p_mem, p_wb;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_rwren     (id_rwren),
        .id_halt      (id_halt),
        .wb_rwren     (wb_rwren),
        .wb_rd        (wb_rd),
        .ex_redirect  (ex_redirect),
        .stall_if_id  (stall_if_id),
        .bubble_id_ex (bubble_id_ex),
        .flush_if_id  (flush_if_id),
        .issue        (issue),
        .halted       (halted),
        .state        (state)
    );

    assign dut_vec = {stall_if_id, bubble_id_ex, flush_if_id, issue, halted, state};

    // {stall, bubble, flush, issue, halted, state} expected for the current inputs.
    function automatic logic [6:0] model_vec();
        logic st, bu, fl, is, ha;
        bit   src1, src2;
        st = 1'b0; bu = 1'b0; fl = 1'b0; is = 1'b0; ha = 1'b0;
        src1 = id_rs1_used && id_rs1 != 0 && m_cnt[id_rs1] > 0;
        src2 = id_rs2_used && id_rs2 != 0 && m_cnt[id_rs2] > 0;
        if (m_state == 0) begin
            if (ex_redirect) begin
                fl = 1'b1; bu = 1'b1;
            end else if (id_valid && (src1 || src2)) begin
                st = 1'b1; bu = 1'b1;
            end else begin
                is = id_valid;
            end
        end else begin
            st = 1'b1; bu = 1'b1; ha = (m_state == 2);
        end
        return {st, bu, fl, is, ha, 2'(m_state)};
    endfunction

    task automatic clear_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_rwren = 0; id_halt = 0; wb_rwren = 0; wb_rd = 0; ex_redirect = 0;
    endtask

    task automatic model_reset();
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_state = 0;
        p_ex = -1; p_mem = -1; p_wb = -1;
    endtask

    // Advance one clock; the model consumes the inputs held across the edge.
    task automatic tick();
        logic [6:0] e;
        bit inc, dec, clear;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            e = model_vec();
            clear = 1;
            foreach (m_cnt[r]) if (m_cnt[r] != 0) clear = 0;
            inc = e[3] && id_rwren && id_rd != 0 && !id_halt;
            dec = wb_rwren && wb_rd != 0;
            if (!(inc && dec && id_rd == wb_rd)) begin
                if (inc && m_cnt[id_rd] < 3) m_cnt[id_rd]++;
                if (dec && m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
            end
            if (m_state == 0 && e[3] && id_halt) m_state = 1;
            else if (m_state == 1 && clear) m_state = 2;
        end
        #1;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1; clear_inputs(); model_reset();
        #12;
        checks++;
        if (dut_vec !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", dut_vec, 7'b0);
        end
        @(negedge clk); rst = 0;
        tick();
        bad = 0;
        for (int r = 0; r < 32; r++) if (dut.u_sb.cnt_q[r] !== 2'd0) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_counts got=%0d nonzero want=0", bad);
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs(); id_valid = 1; id_rd = 5; id_rwren = 1;
        @(negedge clk);
        checks++;
        if ({stall_if_id, issue} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_producer got=%b want=01", {stall_if_id, issue});
        end
        tick();
        clear_inputs(); id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
        for (int k = 0; k < 3; k++) begin
            wb_rwren = (k == 2); wb_rd = (k == 2) ? 5'd5 : 5'd0;
            @(negedge clk);
            checks++;
            if ({stall_if_id, bubble_id_ex, issue} !== 3'b110) begin
                failures++;
                $display("FAIL b2b_stall cycle=%0d got=%b want=110", k,
                         {stall_if_id, bubble_id_ex, issue});
            end
            tick();
        end
        wb_rwren = 0; wb_rd = 0;
        @(negedge clk);
        checks++;
        if ({stall_if_id, bubble_id_ex, issue} !== 3'b001) begin
            failures++;
            $display("FAIL b2b_release got=%b want=001", {stall_if_id, bubble_id_ex, issue});
        end
        checks++;
        if (dut.u_sb.cnt_q[5] !== 2'd0) begin
            failures++;
            $display("FAIL b2b_cnt5 got=%0d want=0", dut.u_sb.cnt_q[5]);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_x0_unused();
        clear_inputs(); id_valid = 1; id_rd = 0; id_rwren = 1;
        tick();
        clear_inputs(); id_valid = 1; id_rs1 = 0; id_rs1_used = 1; id_rs2_used = 1;
        @(negedge clk);
        checks++;
        if ({stall_if_id, issue} !== 2'b01 || dut.u_sb.cnt_q[0] !== 2'd0) begin
            failures++;
            $display("FAIL x0_read got=%b cnt0=%0d want=01 cnt0=0", {stall_if_id, issue},
                     dut.u_sb.cnt_q[0]);
        end
        tick();
        clear_inputs(); id_valid = 1; id_rd = 7; id_rwren = 1;
        tick();
        clear_inputs(); id_valid = 1; id_rs1 = 7; id_rs2 = 7;
        @(negedge clk);
        checks++;
        if ({stall_if_id, issue} !== 2'b01) begin
            failures++;
            $display("FAIL unused_src got=%b want=01", {stall_if_id, issue});
        end
        tick();
        checks++;
        if (dut.u_sb.cnt_q[7] !== 2'd1) begin
            failures++;
            $display("FAIL unused_cnt7 got=%0d want=1", dut.u_sb.cnt_q[7]);
        end
        clear_inputs(); wb_rwren = 1; wb_rd = 7;
        tick();
        clear_inputs();
    endtask

    task automatic test_redirect();
        clear_inputs(); id_valid = 1; id_rd = 6; id_rwren = 1;
        tick();
        clear_inputs(); id_valid = 1; id_rs1 = 6; id_rs1_used = 1; id_rd = 8; id_rwren = 1;
        ex_redirect = 1;
        @(negedge clk);
        checks++;
        if ({flush_if_id, bubble_id_ex, stall_if_id, issue} !== 4'b1100) begin
            failures++;
            $display("FAIL redirect_outputs got=%b want=1100",
                     {flush_if_id, bubble_id_ex, stall_if_id, issue});
        end
        tick();
        checks++;
        if (dut.u_sb.cnt_q[8] !== 2'd0 || dut.u_sb.cnt_q[6] !== 2'd1) begin
            failures++;
            $display("FAIL redirect_cnt got=%0d/%0d want=0/1", dut.u_sb.cnt_q[8],
                     dut.u_sb.cnt_q[6]);
        end
        clear_inputs(); wb_rwren = 1; wb_rd = 6;
        tick();
        clear_inputs();
    endtask

    task automatic test_simul_inc_dec();
        clear_inputs(); id_valid = 1; id_rd = 9; id_rwren = 1;
        tick();
        wb_rwren = 1; wb_rd = 9;
        @(negedge clk);
        checks++;
        if (issue !== 1'b1) begin
            failures++;
            $display("FAIL simul_issue got=%b want=1", issue);
        end
        tick();
        checks++;
        if (dut.u_sb.cnt_q[9] !== 2'd1) begin
            failures++;
            $display("FAIL simul_cnt9 got=%0d want=1", dut.u_sb.cnt_q[9]);
        end
        clear_inputs(); wb_rwren = 1; wb_rd = 9;
        tick();
        clear_inputs();
        checks++;
        if (dut.u_sb.cnt_q[9] !== 2'd0) begin
            failures++;
            $display("FAIL simul_retire got=%0d want=0", dut.u_sb.cnt_q[9]);
        end
    endtask

    task automatic test_random();
        logic [6:0] e;
        int bad;
        p_ex = -1; p_mem = -1; p_wb = -1;
        for (int c = 0; c < 603; c++) begin
            if (c < 600) begin
                id_valid    = ($urandom_range(0, 3) != 0);
                id_rs1      = 5'($urandom_range(0, 7));
                id_rs2      = 5'($urandom_range(0, 7));
                id_rs1_used = 1'($urandom_range(0, 1));
                id_rs2_used = 1'($urandom_range(0, 1));
                id_rd       = 5'($urandom_range(0, 7));
                id_rwren    = 1'($urandom_range(0, 1));
                ex_redirect = ($urandom_range(0, 7) == 0);
            end else begin
                clear_inputs();
            end
            id_halt = 0;
            if (p_wb >= 0) begin
                wb_rwren = 1; wb_rd = 5'(p_wb);
            end else begin
                wb_rwren = 0; wb_rd = 5'($urandom_range(0, 31));
            end
            @(negedge clk);
            e = model_vec();
            checks++;
            if (dut_vec !== e) begin
                failures++;
                $display("FAIL rand_outputs cycle=%0d got=%b want=%b", c, dut_vec, e);
            end
            checks++;
            if ((flush_if_id && stall_if_id) || (issue && bubble_id_ex)) begin
                failures++;
                $display("FAIL rand_exclusive cycle=%0d got=%b", c, dut_vec);
            end
            tick();
            p_wb  = p_mem;
            p_mem = p_ex;
            p_ex  = (e[3] && id_rwren) ? int'(id_rd) : -1;
            bad = 0;
            for (int r = 0; r < 32; r++) if (dut.u_sb.cnt_q[r] !== 2'(m_cnt[r])) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL rand_counts cycle=%0d got=%0d regs differ want=0", c, bad);
            end
        end
        clear_inputs();
    endtask

    task automatic test_halt_drain();
        int n;
        clear_inputs(); id_valid = 1; id_rd = 3; id_rwren = 1;
        tick();
        id_rd = 4;
        tick();
        clear_inputs(); id_valid = 1; id_halt = 1; id_rwren = 1; id_rd = 10;
        @(negedge clk);
        checks++;
        if ({issue, stall_if_id} !== 2'b10) begin
            failures++;
            $display("FAIL halt_issue got=%b want=10", {issue, stall_if_id});
        end
        tick();
        clear_inputs(); id_valid = 1; id_rs1 = 1; ex_redirect = 1; wb_rwren = 1; wb_rd = 3;
        @(negedge clk);
        checks++;
        if (dut_vec !== 7'b1100001) begin
            failures++;
            $display("FAIL drain_entry got=%b want=1100001", dut_vec);
        end
        tick();
        checks++;
        if (dut.u_sb.cnt_q[10] !== 2'd0) begin
            failures++;
            $display("FAIL halt_rd_untracked got=%0d want=0", dut.u_sb.cnt_q[10]);
        end
        wb_rd = 4;
        tick();
        clear_inputs();
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL drain_wait n=%0d got=%b want=%b", n, dut_vec, model_vec());
            end
            if (halted === 1'b1) break;
            tick();
            n++;
        end
        checks++;
        if (halted !== 1'b1 || n != 1) begin
            failures++;
            $display("FAIL halt_reached got=%b after %0d want=1 after 1", halted, n);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            id_valid    = 1'($urandom_range(0, 1));
            id_rs1      = 5'($urandom_range(0, 31));
            id_rd       = 5'($urandom_range(0, 31));
            id_rwren    = 1'($urandom_range(0, 1));
            ex_redirect = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (dut_vec !== 7'b1100110) begin
                failures++;
                $display("FAIL halted_sticky cycle=%0d got=%b want=1100110", c, dut_vec);
            end
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_async_reset();
        @(negedge clk); rst = 1;
        tick();
        @(negedge clk); rst = 0;
        tick();
        clear_inputs(); id_valid = 1; id_rd = 11; id_rwren = 1;
        tick();
        clear_inputs(); id_valid = 1; id_halt = 1;
        tick();
        clear_inputs(); id_valid = 1; id_rs1 = 11; id_rs1_used = 1;
        @(negedge clk);
        checks++;
        if ({state, stall_if_id} !== 3'b011) begin
            failures++;
            $display("FAIL pre_reset_drain got=%b want=011", {state, stall_if_id});
        end
        #2; rst = 1; #1;
        checks++;
        if ({state, halted, stall_if_id, bubble_id_ex} !== 5'b00000) begin
            failures++;
            $display("FAIL async_reset got=%b want=00000",
                     {state, halted, stall_if_id, bubble_id_ex});
        end
        checks++;
        if (dut.u_sb.cnt_q[11] !== 2'd0) begin
            failures++;
            $display("FAIL async_reset_cnt got=%0d want=0", dut.u_sb.cnt_q[11]);
        end
        model_reset();
        tick();
        @(negedge clk); rst = 0;
        tick();
        @(negedge clk);
        checks++;
        if (dut_vec !== model_vec()) begin
            failures++;
            $display("FAIL post_reset_issue got=%b want=%b", dut_vec, model_vec());
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_x0_unused();
        test_redirect();
        test_simul_inc_dec();
        test_random();
        test_halt_drain();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
